alfsr_seq: RTL and testbench

ALFSR_SEQ -- requirements
Module: alfsr_seq

---
 rtl/alfsr_seq.sv | 171 +++++++++++++++++
 tb/tb_alfsr_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alfsr_seq.sv
// Sequencer for an analog LFSR: serially configures it, waits out warm-up,
// watches the health-test flags and retries with a rotated word on failure.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; ALFSR and health test held in reset
// S_SHIFT  | shadow word clocked out MSB first on lfsr_clk / lfsr_din
// S_SETTLE | 2-cycle gap before releasing the resets
// S_WARMUP | resets released, health-test errors ignored
// S_RUN    | rng_valid high, registered err_in monitored
// S_FAULT  | 4-cycle reset pulse, then retry or give up
// S_DEAD   | retry budget exhausted; fail high until stop or rst
module alfsr_seq #(
  parameter int CFG_W     = 16,
  parameter int CLK_DIV   = 4,
  parameter int WARMUP    = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [3:0]       err_in,
  output logic             lfsr_clk,
  output logic             lfsr_din,
  output logic             alfsr_rst_n,
  output logic             nist_rstn,
  output logic             rng_valid,
  output logic             busy,
  output logic             fail,
  output logic [1:0]       retry_cnt
);

  localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [7:0]    DIV_LD    = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LD    = BW'(CFG_W - 1);
  localparam logic [15:0]   WU_LD     = 16'(WARMUP);
  localparam logic [1:0]    RETRY_TOP = 2'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_SETTLE, S_WARMUP, S_RUN, S_FAULT, S_DEAD
  } state_t;

  state_t           state, state_nx;
  logic [CFG_W-1:0] shadow, shadow_nx;
  logic [7:0]       div_cnt, div_nx;
  logic [BW-1:0]    bit_cnt, bit_nx;
  logic [15:0]      tmr, tmr_nx;
  logic [1:0]       retry_nx;
  logic [3:0]       err_q;
  logic             din_nx, lclk_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    div_nx    = div_cnt;
    bit_nx    = bit_cnt;
    tmr_nx    = tmr;
    retry_nx  = retry_cnt;
    din_nx    = lfsr_din;
    lclk_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          shadow_nx = cfg_word;
          retry_nx  = '0;
          state_nx  = S_SHIFT;
          div_nx    = DIV_LD;
          bit_nx    = BIT_LD;
          din_nx    = cfg_word[CFG_W-1];
        end
      end
      S_SHIFT: begin
        // data only moves on the falling half so it is stable at the rise
        if (div_cnt == 8'd0) begin
          div_nx = DIV_LD;
          if (!lfsr_clk) begin
            lclk_nx = 1'b1;
          end else if (bit_cnt == '0) begin
            state_nx = S_SETTLE;
            tmr_nx   = 16'd1;
          end else begin
            bit_nx = bit_cnt - BW'(1);
            din_nx = shadow[bit_nx];
          end
        end else begin
          div_nx  = div_cnt - 8'd1;
          lclk_nx = lfsr_clk;
        end
      end
      S_SETTLE: begin
        if (tmr == 16'd0) begin
          state_nx = S_WARMUP;
          tmr_nx   = WU_LD;
        end else begin
          tmr_nx = tmr - 16'd1;
        end
      end
      S_WARMUP: begin
        if (tmr == 16'd0) state_nx = S_RUN;
        else              tmr_nx   = tmr - 16'd1;
      end
      S_RUN: begin
        if (|err_q) begin
          state_nx = S_FAULT;
          tmr_nx   = 16'd3;
        end
      end
      S_FAULT: begin
        if (tmr != 16'd0) begin
          tmr_nx = tmr - 16'd1;
        end else if (retry_cnt == RETRY_TOP) begin
          state_nx = S_DEAD;
        end else begin
          retry_nx  = retry_cnt + 2'd1;
          shadow_nx = {shadow[CFG_W-2:0], shadow[CFG_W-1]};
          state_nx  = S_SHIFT;
          div_nx    = DIV_LD;
          bit_nx    = BIT_LD;
          din_nx    = shadow[CFG_W-2];
        end
      end
      S_DEAD: ;
      default: state_nx = S_IDLE;
    endcase
    if (stop && state != S_IDLE) begin
      state_nx = S_IDLE;
      lclk_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tmr         <= '0;
      err_q       <= '0;
      retry_cnt   <= '0;
      lfsr_clk    <= 1'b0;
      lfsr_din    <= 1'b0;
      alfsr_rst_n <= 1'b0;
      nist_rstn   <= 1'b0;
      rng_valid   <= 1'b0;
      busy        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      shadow      <= shadow_nx;
      div_cnt     <= div_nx;
      bit_cnt     <= bit_nx;
      tmr         <= tmr_nx;
      // flags seen before RUN never reach the fault check
      err_q       <= (state == S_RUN) ? err_in : 4'd0;
      retry_cnt   <= retry_nx;
      lfsr_clk    <= lclk_nx;
      lfsr_din    <= din_nx;
      alfsr_rst_n <= (state_nx == S_WARMUP) || (state_nx == S_RUN);
      nist_rstn   <= (state_nx == S_WARMUP) || (state_nx == S_RUN);
      rng_valid   <= (state_nx == S_RUN);
      busy        <= (state_nx != S_IDLE);
      fail        <= (state_nx == S_DEAD);
    end
  end

endmodule

// File: tb/tb_alfsr_seq.sv
// Scoreboard bench for alfsr_seq: stimulus queues expected serial bits and
// rng_valid rise times, a monitor pops and compares as the DUT produces them.
module tb_alfsr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_word = 16'h0000;
  logic [3:0]  err_in = 4'h0;
  logic        lfsr_clk, lfsr_din, alfsr_rst_n, nist_rstn;
  logic        rng_valid, busy, fail;
  logic [1:0]  retry_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  bit bit_q[$];
  int lat_q[$];

  alfsr_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_word(cfg_word),
    .err_in(err_in), .lfsr_clk(lfsr_clk), .lfsr_din(lfsr_din),
    .alfsr_rst_n(alfsr_rst_n), .nist_rstn(nist_rstn), .rng_valid(rng_valid),
    .busy(busy), .fail(fail), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // monitor: serial bits, lfsr_clk half-periods, rng_valid latency
  logic lclk_prev = 1'b0, rv_prev = 1'b0;
  bit   have_fall = 1'b0;
  int   hi_len = 0, low_len = 0;

  always @(negedge clk) begin
    if (lfsr_clk && !lclk_prev) begin
      if (have_fall) chk("low_time", low_len, 4);
      if (bit_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_bit: got lfsr_clk rise, expected none (cycle %0d)", cyc);
      end else begin
        bit eb;
        eb = bit_q.pop_front();
        chk("lfsr_din", int'(lfsr_din), int'(eb));
      end
      hi_len = 1;
    end else if (lfsr_clk) begin
      hi_len++;
    end
    if (!lfsr_clk && lclk_prev) begin
      chk("high_time", hi_len, 4);
      have_fall = (bit_q.size() != 0);
      low_len = 1;
    end else if (!lfsr_clk) begin
      low_len++;
    end
    if (rng_valid && !rv_prev) begin
      if (lat_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_valid: got rng_valid rise, expected none (cycle %0d)", cyc);
      end else begin
        chk("valid_latency", cyc, lat_q.pop_front());
      end
    end
    lclk_prev = lfsr_clk;
    rv_prev = rng_valid;
  end

  task automatic push_bits(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bit_q.push_back(w[i]);
  endtask

  task automatic flush();
    bit_q.delete();
    lat_q.delete();
    have_fall = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] w, output int n);
    cfg_word = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = cyc;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_rng(input int budget);
    int k;
    k = 0;
    while (!rng_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!rng_valid) begin
      n_cmp++; n_err++;
      $display("FAIL rng_timeout: got rng_valid=0, expected 1 within %0d cycles", budget);
    end
  endtask

  // err pulse in RUN; returns the negedge cycle k at which err was driven
  task automatic err_pulse(output int k);
    k = cyc;
    err_in = 4'b0100;
    @(negedge clk);
    err_in = 4'h0;
    @(negedge clk);
    chk("fault_valid_low", int'(rng_valid), 0);
    chk("fault_alfsr_rst", int'(alfsr_rst_n), 0);
    chk("fault_nist_rst", int'(nist_rstn), 0);
    wait_to(k + 5);
    chk("fault_hold_rst", int'(alfsr_rst_n), 0);
    wait_to(k + 6);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lfsr_clk"}, int'(lfsr_clk), 0);
    chk({tag, "_lfsr_din"}, int'(lfsr_din), 0);
    chk({tag, "_alfsr_rst_n"}, int'(alfsr_rst_n), 0);
    chk({tag, "_nist_rstn"}, int'(nist_rstn), 0);
    chk({tag, "_rng_valid"}, int'(rng_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_retry"}, int'(retry_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // nominal run, then three consecutive faults to DEAD
    push_bits(16'hA5C3);
    do_start(16'hA5C3, n);
    lat_q.push_back(n + 195);
    chk("busy_after_start", int'(busy), 1);
    chk("shift_rst_low", int'(alfsr_rst_n), 0);
    wait_rng(260);
    chk("run_alfsr_rst", int'(alfsr_rst_n), 1);
    chk("run_nist_rst", int'(nist_rstn), 1);
    repeat (3) @(negedge clk);

    push_bits(16'h4B87);
    err_pulse(k);
    lat_q.push_back(k + 201);
    chk("retry_1", int'(retry_cnt), 1);
    chk("retry_busy", int'(busy), 1);
    wait_rng(260);
    repeat (2) @(negedge clk);

    push_bits(16'h970E);
    err_pulse(k);
    lat_q.push_back(k + 201);
    chk("retry_2", int'(retry_cnt), 2);
    wait_rng(260);
    repeat (2) @(negedge clk);

    err_pulse(k);
    chk("dead_fail", int'(fail), 1);
    chk("dead_retry_sat", int'(retry_cnt), 2);
    chk("dead_busy", int'(busy), 1);
    chk("dead_rst", int'(alfsr_rst_n), 0);
    do_start(16'hFFFF, n);
    repeat (12) @(negedge clk);
    chk("dead_ignores_start", int'(fail), 1);
    chk("dead_retry_hold", int'(retry_cnt), 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_dead_fail", int'(fail), 0);
    chk("stop_dead_busy", int'(busy), 0);
    repeat (2) @(negedge clk);

    // errors during warm-up ignored; cfg_word change mid-shift ignored
    push_bits(16'h0001);
    do_start(16'h0001, n);
    lat_q.push_back(n + 195);
    wait_to(n + 20);
    cfg_word = 16'hFFFF;
    wait_to(n + 131);
    err_in = 4'hF;
    wait_to(n + 191);
    err_in = 4'h0;
    wait_rng(20);
    wait_to(n + 200);
    chk("warmup_err_valid", int'(rng_valid), 1);
    chk("warmup_err_retry", int'(retry_cnt), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_run_valid", int'(rng_valid), 0);
    chk("stop_run_busy", int'(busy), 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    chk("start_stop_idle", int'(busy), 0);

    // stop during bit 7 of SHIFT
    push_bits(16'hF0F0);
    do_start(16'hF0F0, n);
    wait_to(n + 57);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_shift_lclk", int'(lfsr_clk), 0);
    chk("stop_shift_busy", int'(busy), 0);
    chk("stop_shift_rst", int'(alfsr_rst_n), 0);
    chk("stop_shift_bits_seen", 16 - bit_q.size(), 7);
    repeat (2) @(negedge clk);
    flush();
    repeat (20) @(negedge clk);

    // async reset during WARMUP, then full latency again
    push_bits(16'hC35B);
    do_start(16'hC35B, n);
    lat_q.push_back(n + 195);
    wait_to(n + 150);
    chk("pre_rst_rst_n", int'(alfsr_rst_n), 1);
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    flush();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_bits(16'hC35B);
    do_start(16'hC35B, n);
    lat_q.push_back(n + 195);
    wait_rng(260);
    repeat (3) @(negedge clk);

    chk("bits_drained", bit_q.size(), 0);
    chk("lat_drained", lat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
